// File: rtl/crc_feed_pkg.sv
// Shared definitions for the CRC feeder: register map, CRC engine addresses, datatypes, FSM states.
package crc_feed_pkg;

    localparam logic [31:0] RegSrc    = 32'h0000_0000;
    localparam logic [31:0] RegLen    = 32'h0000_0004;
    localparam logic [31:0] RegCtrl   = 32'h0000_0008;
    localparam logic [31:0] RegStatus = 32'h0000_000C;

    localparam logic [2:0] DtByte = 3'd0;
    localparam logic [2:0] DtHalf = 3'd1;
    localparam logic [2:0] DtWord = 3'd2;

    localparam logic [31:0] CrcCtrlAddr   = 32'h0000_0040;
    localparam logic [31:0] CrcDataAddr   = 32'h0000_0044;
    localparam logic [31:0] CrcStatusAddr = 32'h0000_0048;

    localparam int unsigned PollLimit = 64;

    typedef enum logic [2:0] {
        StIdle,
        StCfg,
        StFetch,
        StLoad,
        StPush,
        StPollReq,
        StPollChk,
        StFin
    } state_e;

    function automatic logic [31:0] crc_ctrl_word(input logic [2:0] dtype, input logic cont);
        return {28'b0, dtype, cont};
    endfunction

endpackage

// File: rtl/crc_feed_regs.sv
// CPU-visible register file of the CRC feeder with registered read mux.
// Define CRC_FEED_IRQ_EN to enable the CTRL.bit4-gated done interrupt.
module crc_feed_regs
    import crc_feed_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] feed_r_addr_i,
    input  logic [31:0] feed_w_addr_i,
    input  logic [31:0] feed_data_i,
    input  logic        feed_r_enable_i,
    input  logic        feed_w_enable_i,
    output logic [31:0] feed_data_o,
    input  logic        busy_i,
    input  logic        done_set_i,
    input  logic        timeout_set_i,
    output logic        start_o,
    output logic [31:0] src_o,
    output logic [15:0] len_o,
    output logic [2:0]  dtype_o,
    output logic        irq_o
);

    logic [31:0] src_q;
    logic [15:0] len_q;
    logic [2:0]  dtype_q;
    logic        done_q, timeout_q;
    logic        irq_en;
    logic        wr_src, wr_len, wr_ctrl, rd_status;
    logic [31:0] rdata;

    // Configuration is frozen for the whole transfer.
    assign wr_src    = feed_w_enable_i && (feed_w_addr_i == RegSrc) && !busy_i;
    assign wr_len    = feed_w_enable_i && (feed_w_addr_i == RegLen) && !busy_i;
    assign wr_ctrl   = feed_w_enable_i && (feed_w_addr_i == RegCtrl) && !busy_i;
    assign rd_status = feed_r_enable_i && (feed_r_addr_i == RegStatus);
    assign start_o   = wr_ctrl && feed_data_i[0];

    assign src_o   = src_q;
    assign len_o   = len_q;
    assign dtype_o = dtype_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q       <= 32'b0;
            len_q       <= 16'b0;
            dtype_q     <= DtWord;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            feed_data_o <= 32'b0;
        end else begin
            if (wr_src) src_q <= {feed_data_i[31:2], 2'b00};
            if (wr_len) len_q <= feed_data_i[15:0];
            if (wr_ctrl) dtype_q <= feed_data_i[3:1];
            // A set in the same cycle as a STATUS read wins over the clear.
            done_q    <= done_set_i | (done_q & ~rd_status);
            timeout_q <= timeout_set_i | (timeout_q & ~rd_status);
            if (feed_r_enable_i) feed_data_o <= rdata;
        end
    end

`ifdef CRC_FEED_IRQ_EN
    logic irq_en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q <= 1'b0;
        end else if (wr_ctrl) begin
            irq_en_q <= feed_data_i[4];
        end
    end

    assign irq_en = irq_en_q;
    assign irq_o  = done_q & irq_en_q;
`else
    assign irq_en = 1'b0;
    assign irq_o  = 1'b0;
`endif

    always_comb begin
        rdata = 32'b0;
        case (feed_r_addr_i)
            RegSrc:    rdata = src_q;
            RegLen:    rdata = {16'b0, len_q};
            RegCtrl:   rdata = {27'b0, irq_en, dtype_q, 1'b0};
            RegStatus: rdata = {29'b0, timeout_q, done_q, busy_i};
            default:   rdata = 32'b0;
        endcase
    end

endmodule

// File: rtl/crc_feed.sv
// CRC feeder: streams LEN memory words from SRC into a CRC engine, polling completion per element.
module crc_feed
    import crc_feed_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] feed_r_addr_i,
    input  logic [31:0] feed_w_addr_i,
    input  logic [31:0] feed_data_i,
    input  logic        feed_r_enable_i,
    input  logic        feed_w_enable_i,
    output logic [31:0] feed_data_o,
    output logic [31:0] mem_r_addr_o,
    output logic        mem_r_enable_o,
    input  logic [31:0] mem_data_i,
    output logic [31:0] crc_w_addr_o,
    output logic [31:0] crc_w_data_o,
    output logic        crc_w_enable_o,
    output logic [31:0] crc_r_addr_o,
    output logic        crc_r_enable_o,
    input  logic [31:0] crc_data_i,
    output logic        irq_o
);

    localparam logic [5:0] PollLast = 6'(PollLimit - 1);

    state_e      state_q, state_d;
    logic [31:0] ptr_q, ptr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic [5:0]  poll_q, poll_d;
    logic        started_q, started_d;
    logic        tmo_q, tmo_d;

    logic        start, busy, done_set, timeout_set;
    logic [31:0] src;
    logic [15:0] len;
    logic [2:0]  dtype;

    logic unused_crc_data;
    assign unused_crc_data = ^crc_data_i[31:1];

    assign busy = (state_q != StIdle);

    crc_feed_regs u_regs (
        .clk            (clk),
        .rst_n          (rst_n),
        .feed_r_addr_i  (feed_r_addr_i),
        .feed_w_addr_i  (feed_w_addr_i),
        .feed_data_i    (feed_data_i),
        .feed_r_enable_i(feed_r_enable_i),
        .feed_w_enable_i(feed_w_enable_i),
        .feed_data_o    (feed_data_o),
        .busy_i         (busy),
        .done_set_i     (done_set),
        .timeout_set_i  (timeout_set),
        .start_o        (start),
        .src_o          (src),
        .len_o          (len),
        .dtype_o        (dtype),
        .irq_o          (irq_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= 32'b0;
            cnt_q     <= 16'b0;
            word_q    <= 32'b0;
            poll_q    <= 6'b0;
            started_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            poll_q    <= poll_d;
            started_q <= started_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        cnt_d          = cnt_q;
        word_d         = word_q;
        poll_d         = poll_q;
        started_d      = started_q;
        tmo_d          = tmo_q;
        mem_r_addr_o   = 32'b0;
        mem_r_enable_o = 1'b0;
        crc_w_addr_o   = 32'b0;
        crc_w_data_o   = 32'b0;
        crc_w_enable_o = 1'b0;
        crc_r_addr_o   = 32'b0;
        crc_r_enable_o = 1'b0;
        done_set       = 1'b0;
        timeout_set    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ptr_d     = src;
                    cnt_d     = len;
                    started_d = 1'b0;
                    tmo_d     = 1'b0;
                    state_d   = (len == 16'd0) ? StFin : StCfg;
                end
            end
            StCfg: begin
                crc_w_enable_o = 1'b1;
                crc_w_addr_o   = CrcCtrlAddr;
                crc_w_data_o   = crc_ctrl_word(dtype, 1'b1);
                started_d      = 1'b1;
                state_d        = StFetch;
            end
            StFetch: begin
                mem_r_enable_o = 1'b1;
                mem_r_addr_o   = ptr_q;
                state_d        = StLoad;
            end
            StLoad: begin
                word_d  = mem_data_i;
                state_d = StPush;
            end
            StPush: begin
                crc_w_enable_o = 1'b1;
                crc_w_addr_o   = CrcDataAddr;
                crc_w_data_o   = word_q;
                poll_d         = 6'd0;
                state_d        = StPollReq;
            end
            StPollReq: begin
                crc_r_enable_o = 1'b1;
                crc_r_addr_o   = CrcStatusAddr;
                state_d        = StPollChk;
            end
            StPollChk: begin
                if (crc_data_i[0]) begin
                    cnt_d   = cnt_q - 16'd1;
                    ptr_d   = ptr_q + 32'd4;
                    state_d = (cnt_q == 16'd1) ? StFin : StFetch;
                end else if (poll_q == PollLast) begin
                    tmo_d   = 1'b1;
                    state_d = StFin;
                end else begin
                    poll_d  = poll_q + 6'd1;
                    state_d = StPollReq;
                end
            end
            StFin: begin
                // A zero-length start never opened a CRC session, so there is nothing to close.
                if (started_q) begin
                    crc_w_enable_o = 1'b1;
                    crc_w_addr_o   = CrcCtrlAddr;
                    crc_w_data_o   = crc_ctrl_word(dtype, 1'b0);
                end
                done_set    = 1'b1;
                timeout_set = tmo_q;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_crc_feed.sv
// Scoreboard bench for crc_feed: memory and CRC-engine stubs, expected bus transactions queued per transfer.
module tb_crc_feed;
    import crc_feed_pkg::*;

    localparam logic [1:0] KMem  = 2'd0;
    localparam logic [1:0] KCrcW = 2'd1;
    localparam logic [1:0] KCrcR = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] feed_r_addr_i = 32'b0, feed_w_addr_i = 32'b0, feed_data_i = 32'b0;
    logic        feed_r_enable_i = 1'b0, feed_w_enable_i = 1'b0;
    logic [31:0] feed_data_o;
    logic [31:0] mem_r_addr_o, mem_data_i;
    logic        mem_r_enable_o;
    logic [31:0] crc_w_addr_o, crc_w_data_o, crc_r_addr_o, crc_data_i;
    logic        crc_w_enable_o, crc_r_enable_o, irq_o;

    int checks = 0;
    int failures = 0;

    txn_t        exp_q[$];
    int          lat_q[$];
    logic [31:0] mem_a[logic [31:0]];
    bit          stuck = 1'b0;
    int          pend;
    bit          cont_mode;
    logic [2:0]  crc_dt;
    logic [31:0] crc_acc;

    always #5 clk = ~clk;

    crc_feed dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .feed_r_addr_i  (feed_r_addr_i),
        .feed_w_addr_i  (feed_w_addr_i),
        .feed_data_i    (feed_data_i),
        .feed_r_enable_i(feed_r_enable_i),
        .feed_w_enable_i(feed_w_enable_i),
        .feed_data_o    (feed_data_o),
        .mem_r_addr_o   (mem_r_addr_o),
        .mem_r_enable_o (mem_r_enable_o),
        .mem_data_i     (mem_data_i),
        .crc_w_addr_o   (crc_w_addr_o),
        .crc_w_data_o   (crc_w_data_o),
        .crc_w_enable_o (crc_w_enable_o),
        .crc_r_addr_o   (crc_r_addr_o),
        .crc_r_enable_o (crc_r_enable_o),
        .crc_data_i     (crc_data_i),
        .irq_o          (irq_o)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem_a.exists(a)) return mem_a[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // CRC-32/MPEG-2 style engine: MSB-first, poly 0x04C11DB7, element width from datatype.
    function automatic logic [31:0] crc_elem(input logic [31:0] acc_in, input logic [31:0] w,
                                             input logic [2:0] dt);
        logic [31:0] acc;
        logic [7:0]  by;
        logic        fb;
        int          nb;
        acc = acc_in;
        nb  = (dt == DtByte) ? 1 : (dt == DtHalf) ? 2 : 4;
        for (int b = nb - 1; b >= 0; b--) begin
            by = w[8*b +: 8];
            for (int i = 7; i >= 0; i--) begin
                fb  = acc[31] ^ by[i];
                acc = {acc[30:0], 1'b0};
                if (fb) acc = acc ^ 32'h04C1_1DB7;
            end
        end
        return acc;
    endfunction

    // Memory answers one cycle after the request; garbage otherwise.
    always @(posedge clk) begin
        mem_data_i <= mem_r_enable_o ? mem_val(mem_r_addr_o) : 32'hDEAD_BEEF;
    end

    // CRC engine stub: completion reported after a per-element number of status reads.
    always @(posedge clk or negedge rst_n) begin
        logic [31:0] rnd;
        if (!rst_n) begin
            pend       <= 0;
            cont_mode  <= 1'b0;
            crc_dt     <= DtWord;
            crc_acc    <= 32'hFFFF_FFFF;
            crc_data_i <= 32'b0;
            lat_q.delete();
        end else begin
            rnd = $urandom();
            crc_data_i <= rnd;
            if (crc_w_enable_o && crc_w_addr_o == CrcCtrlAddr) begin
                if (crc_w_data_o[0] && !cont_mode) crc_acc <= 32'hFFFF_FFFF;
                cont_mode <= crc_w_data_o[0];
                crc_dt    <= crc_w_data_o[3:1];
            end
            if (crc_w_enable_o && crc_w_addr_o == CrcDataAddr) begin
                crc_acc <= crc_elem(crc_acc, crc_w_data_o, crc_dt);
                pend    <= (lat_q.size() > 0) ? lat_q.pop_front() : 0;
            end
            if (crc_r_enable_o) begin
                crc_data_i <= {rnd[31:1], (!stuck && pend == 0)};
                if (!stuck && pend != 0) pend <= pend - 1;
            end
        end
    end

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        txn_t got, e;
        int   n;
        if (rst_n) begin
            n = int'(mem_r_enable_o) + int'(crc_w_enable_o) + int'(crc_r_enable_o);
            if (n > 1) begin
                checks++;
                failures++;
                $display("FAIL strobe_exclusive got=%0d strobes required<=1 t=%0t", n, $time);
            end else if (n == 1) begin
                if (mem_r_enable_o) got = '{kind: KMem, addr: mem_r_addr_o, data: 32'b0};
                else if (crc_w_enable_o)
                    got = '{kind: KCrcW, addr: crc_w_addr_o, data: crc_w_data_o};
                else got = '{kind: KCrcR, addr: crc_r_addr_o, data: 32'b0};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_txn got kind=%0d addr=%h data=%h required none t=%0t",
                             got.kind, got.addr, got.data, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL txn got kind=%0d addr=%h data=%h required kind=%0d addr=%h data=%h t=%0t",
                                 got.kind, got.addr, got.data, e.kind, e.addr, e.data, $time);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        feed_w_addr_i   = a;
        feed_data_i     = d;
        feed_w_enable_i = 1'b1;
        @(negedge clk);
        feed_w_enable_i = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        feed_r_addr_i   = a;
        feed_r_enable_i = 1'b1;
        @(negedge clk);
        feed_r_enable_i = 1'b0;
        d = feed_data_o;
    endtask

    // Reference: CFG ctrl, then per element read/push/polls, then closing ctrl.
    task automatic start_transfer(input logic [31:0] src, input int len, input logic [2:0] dt);
        logic [31:0] a;
        int          lat;
        if (len > 0) begin
            exp_q.push_back('{kind: KCrcW, addr: CrcCtrlAddr, data: {28'b0, dt, 1'b1}});
            for (int i = 0; i < len; i++) begin
                a = src + 32'(4 * i);
                exp_q.push_back('{kind: KMem, addr: a, data: 32'b0});
                exp_q.push_back('{kind: KCrcW, addr: CrcDataAddr, data: mem_val(a)});
                if (stuck) begin
                    repeat (64) exp_q.push_back('{kind: KCrcR, addr: CrcStatusAddr, data: 32'b0});
                    break;
                end
                lat = $urandom_range(0, 3);
                lat_q.push_back(lat);
                repeat (lat + 1) exp_q.push_back('{kind: KCrcR, addr: CrcStatusAddr, data: 32'b0});
            end
            exp_q.push_back('{kind: KCrcW, addr: CrcCtrlAddr, data: {28'b0, dt, 1'b0}});
        end
        cpu_write(RegSrc, src);
        cpu_write(RegLen, 32'(len));
        cpu_write(RegCtrl, {28'b0, dt, 1'b1});
    endtask

    task automatic finish_transfer(input string name, input logic tmo);
        logic [31:0] st;
        st = 32'b0;
        for (int k = 0; k < 400; k++) begin
            cpu_read(RegStatus, st);
            if (st[1]) break;
        end
        check({name, "_status"}, st, {29'b0, tmo, 1'b1, 1'b0});
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        cpu_read(RegStatus, st);
        check({name, "_done_cleared"}, st, 32'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] rd;
        logic [2:0]  dt;
        logic        irq_exp;
        int          k;
`ifdef CRC_FEED_IRQ_EN
        irq_exp = 1'b1;
`else
        irq_exp = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_strobes", {29'b0, mem_r_enable_o, crc_w_enable_o, crc_r_enable_o}, 32'd0);
        check("reset_irq", {31'b0, irq_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        cpu_read(RegSrc, rd);    check("reset_src", rd, 32'd0);
        cpu_read(RegLen, rd);    check("reset_len", rd, 32'd0);
        cpu_read(RegCtrl, rd);   check("reset_ctrl", rd, {28'b0, DtWord, 1'b0});
        cpu_read(RegStatus, rd); check("reset_status", rd, 32'd0);

        // Zero-length start with irq enable: done quickly, no bus activity.
        cpu_write(RegCtrl, {27'b0, 1'b1, DtByte, 1'b1});
        @(negedge clk);
        check("len0_irq", {31'b0, irq_o}, {31'b0, irq_exp});
        cpu_read(RegStatus, rd); check("len0_status", rd, 32'h2);
        check("len0_irq_cleared", {31'b0, irq_o}, 32'd0);
        cpu_read(RegCtrl, rd);   check("ctrl_readback", rd, {27'b0, irq_exp, DtByte, 1'b0});

        // "123456789" one byte per word.
        for (int i = 0; i < 9; i++)
            mem_a[32'h100 + 32'(4 * i)] = {$urandom_range(0, 255), 8'h31 + 8'(i)} & 32'h0000_FFFF;
        start_transfer(32'h100, 9, DtByte);
        finish_transfer("crc_check", 1'b0);
        check("crc_result", crc_acc, 32'h0376_E6E7);

        for (int t = 0; t < 6; t++) begin
            dt = 3'($urandom_range(0, 2));
            start_transfer($urandom() & 32'hFFFF_FFFC, $urandom_range(1, 6), dt);
            finish_transfer("random", 1'b0);
        end

        start_transfer(32'hFFFF_FFFC, 2, DtWord);
        finish_transfer("wrap", 1'b0);

        // Writes while busy must not disturb the running transfer.
        start_transfer(32'h0000_2000, 4, DtHalf);
        repeat (3) @(negedge clk);
        cpu_write(RegSrc, 32'h0000_1000);
        cpu_write(RegLen, 32'd7);
        cpu_write(RegCtrl, {28'b0, DtWord, 1'b1});
        finish_transfer("busy_start", 1'b0);
        cpu_read(RegSrc, rd); check("busy_src_kept", rd, 32'h0000_2000);
        cpu_read(RegLen, rd); check("busy_len_kept", rd, 32'd4);

        stuck = 1'b1;
        start_transfer(32'h0000_3000, 3, DtWord);
        finish_transfer("timeout", 1'b1);
        stuck = 1'b0;

        // Reset while checking a poll result.
        start_transfer(32'h0000_4000, 3, DtByte);
        k = 0;
        while (!crc_r_enable_o && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("reach_poll", {31'b0, crc_r_enable_o}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_strobes", {29'b0, mem_r_enable_o, crc_w_enable_o, crc_r_enable_o}, 32'd0);
        check("rst_outputs", mem_r_addr_o | crc_w_addr_o | crc_w_data_o | crc_r_addr_o, 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cpu_read(RegStatus, rd); check("post_rst_status", rd, 32'd0);
        start_transfer(32'h0000_5000, 1, DtWord);
        finish_transfer("post_reset", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crc_feed.md
CRC_FEED -- requirements
Module: crc_feed

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all flops on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports feed_r_addr_i / feed_w_addr_i, input, 32, CPU register read/write address.
REQ-004 SHALL have ports feed_data_i, input, 32, CPU write data; feed_r_enable_i / feed_w_enable_i, input, 1, read/write strobes.
REQ-005 SHALL have port feed_data_o, output, 32, registered CPU read data.
REQ-006 SHALL have ports mem_r_addr_o, output, 32, and mem_r_enable_o, output, 1: buffer memory read request.
REQ-007 SHALL have port mem_data_i, input, 32, memory read data, valid exactly 1 cycle after the request.
REQ-008 SHALL have ports crc_w_addr_o, output, 32; crc_w_data_o, output, 32; crc_w_enable_o, output, 1: writes to the CRC engine registers.
REQ-009 SHALL have ports crc_r_addr_o, output, 32; crc_r_enable_o, output, 1; crc_data_i, input, 32: CRC status read, data valid 1 cycle after the request.
REQ-010 SHALL have port irq_o, output, 1, transfer-done interrupt (see Configuration).

Function
REQ-011 Registers SHALL be SRC (word-aligned byte address), LEN (element count, 16 bits used), CTRL (bit0 start, bits3:1 datatype, bit4 irq enable), STATUS (bit0 busy, bit1 done, bit2 timeout).
REQ-012 Writing CTRL with bit0=1 while idle SHALL start a transfer; start, SRC and LEN writes while busy SHALL be ignored; bit0 SHALL self-clear.
REQ-013 FSM states: IDLE, CFG, FETCH, LOAD, PUSH, POLL_REQ, POLL_CHK, FIN.
REQ-014 IDLE->CFG on start with LEN!=0; IDLE->FIN on start with LEN=0, with no memory or CRC access.
REQ-015 CFG SHALL write CRC ctrl = {datatype, continue=1} in 1 cycle, then go to FETCH.
REQ-016 FETCH SHALL assert mem_r_enable_o for 1 cycle at the current pointer; LOAD SHALL capture mem_data_i.
REQ-017 PUSH SHALL write the captured word to the CRC data address for 1 cycle, then go to POLL_REQ.
REQ-018 POLL_REQ SHALL read the CRC status address; POLL_CHK SHALL test crc_data_i[0]: if 1, decrement the remaining count and advance the pointer by 4, then go to FETCH (count>0) or FIN (count=0); if 0, return to POLL_REQ.
REQ-019 Each element SHALL occupy one 32-bit memory word; datatype SHALL be passed through unchanged to the CRC engine.
REQ-020 A poll counter SHALL reset per element; after 64 unsuccessful polls, STATUS.timeout=1 and the FSM SHALL go to FIN.
REQ-021 FIN SHALL write CRC ctrl with continue=0 and the same datatype, set STATUS.done=1, clear busy, and go to IDLE.
REQ-022 Reading STATUS SHALL return the value and then clear done and timeout; if set and read in the same cycle, set SHALL win.
REQ-023 Pointer arithmetic SHALL wrap modulo 2^32 with no fault.
REQ-024 Only one of mem, CRC write and CRC read strobes SHALL be active in any cycle.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, all strobes 0, all addresses/data outputs 0, SRC=LEN=0, CTRL=datatype_word, STATUS=0, irq_o=0.
REQ-026 Reset mid-transfer SHALL abandon it with no further CRC writes after release.

Configuration
REQ-027 With CRC_FEED_IRQ_EN defined, irq_o SHALL equal STATUS.done AND CTRL.bit4 (level, cleared by STATUS read).
REQ-028 Without CRC_FEED_IRQ_EN, irq_o SHALL be constant 0 and CTRL.bit4 SHALL read 0.

Structure
REQ-029 Register offsets (src, len, ctrl, status) and FSM state encodings SHALL live in the shared define file; datatype codes and CRC register addresses SHALL be reused from it.
REQ-030 CPU-visible registers and the read mux SHALL be a sub-module crc_feed_regs; the FSM SHALL stay in crc_feed.

Verification
REQ-031 Feed the 9 bytes of "123456789" (one per word), datatype byte, LEN=9 -> done=1 and the CRC result reads 0x0376E6E7.
REQ-032 LEN=0 start -> done=1 within 3 cycles, zero mem/CRC strobes.
REQ-033 Stub the CRC so it never sets complete -> exactly 64 polls, timeout=1, done=1, FIN ctrl write issued.
REQ-034 SRC=0xFFFFFFFC, LEN=2 -> mem addresses 0xFFFFFFFC then 0x00000000.
REQ-035 Start write during busy -> ignored, original transfer completes unchanged; STATUS read -> done cleared next read.
REQ-036 rst_n low during POLL_CHK -> all strobes 0 immediately; after release, a new 1-word transfer completes correctly.
